y86_fde_core: RTL and testbench
===============================

Name: y86_fde_core

Overview:
- Combined Fetch/Decode/Execute front end of the single-cycle (SEQ) Y86-64 processor.
- Contains the instruction byte memory, the 16x64 register file (read side plus externally driven write ports), the ALU and the condition-code register.
- The PC, data memory, writeback selection and next-PC logic sit outside. All datapath outputs are combinational from pc and state; only the register file, the CC register and the instruction-memory load port are clocked.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes; valid byte addresses are 0..IMEM_BYTES-1.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc  in  64  address of the current instruction
- imem_we  in  1  instruction-memory byte write enable (program load)
- imem_waddr  in  64  byte write address; ignored if >= IMEM_BYTES
- imem_wdata  in  8  byte write data
- wb_dstE  in  4  register write port E index; 0xF = no write
- wb_valE  in  64  port E data
- wb_dstM  in  4  register write port M index; 0xF = no write
- wb_valM  in  64  port M data
- icode, ifun, rA, rB  out  4 each  fetched fields
- valC  out  64  constant word
- valP  out  64  pc + instruction length
- instr_valid  out  1  legal icode/ifun
- imem_error  out  1  fetch out of range
- hlt  out  1  icode==0 (halt)
- srcA, srcB, dstE, dstM  out  4 each  decode register ids (0xF = none)
- valA, valB  out  64  register read data
- valE  out  64  ALU result
- cnd  out  1  condition result for jXX/cmovXX
- cc  out  3  {ZF,SF,OF}

Behaviour:
Encodings (icode):
- 0 halt, 1 nop, 2 rrmovq/cmovXX, 3 irmovq, 4 rmmovq, 5 mrmovq, 6 OPq, 7 jXX, 8 call, 9 ret, A pushq, B popq.

Fetch (combinational, little-endian):
- Byte0 = {icode, ifun}.
- Register byte present for 2,3,4,5,6,A,B: rA = high nibble, rB = low nibble. Otherwise rA = rB = 0xF.
- valC present for 3,4,5 (bytes pc+2..pc+9) and 7,8 (bytes pc+1..pc+8). Otherwise valC = 0.
- Lengths: 1 for 0,1,9; 2 for 2,6,A,B; 10 for 3,4,5; 9 for 7,8. valP = pc + length, 64-bit wrap.
- imem_error = 1 if any byte of the instruction (pc through pc+length-1) is >= IMEM_BYTES. If pc itself is out of range, icode = 1 and ifun = 0 (forced nop); all other fields behave as for a nop.
- instr_valid = 0 if icode > 0xB, if OPq ifun > 3, if jXX/cmov ifun > 6, or if any other icode has ifun != 0.
- hlt = (icode == 0).

Decode:
- srcA = rA for 2,4,6,A; 4 (rsp) for 9,B; else 0xF.
- srcB = rB for 4,5,6; 4 for 8,9,A,B; else 0xF.
- dstE = rB for 3,6, and for 2 when cnd = 1; 4 for 8,9,A,B; else 0xF.
- dstM = rA for 5,B; else 0xF.
- valA / valB = register[src], or 0 when src = 0xF.

Register file:
- Reset asynchronously clears all 16 registers to 0.
- On rising clk, wb_dstE and wb_dstM are written when != 0xF. When both target the same register, M wins.
- Reads are combinational and return the old value until the edge.

Execute:
- aluA = valA for 2,6; valC for 3,4,5; -8 for 8,A; +8 for 9,B.
- aluB = valB for 4,5,6,8,9,A,B; 0 for 2,3.
- Function: OPq uses ifun (0 add, 1 sub = aluB - aluA, 2 and, 3 xor); all other icodes add.
- valE = 64-bit wrapped result.
- New flags: ZF = (valE == 0); SF = valE[63]. OF for add: operands have the same sign and the result sign differs. OF for sub: aluA and aluB signs differ and the result sign differs from aluB. OF = 0 for and/xor.
- cc register: resets asynchronously to 3'b100. Loads the new flags on rising clk only when icode = 6, instr_valid = 1, imem_error = 0 and rst_n = 1.
- cnd from the current cc and ifun: 0 always 1; 1 le = (SF^OF)|ZF; 2 l = SF^OF; 3 e = ZF; 4 ne = ~ZF; 5 ge = ~(SF^OF); 6 g = ~(SF^OF)&~ZF; else 0.
- cnd is 0 when icode is neither 2 nor 7.

Imem load:
- Synchronous byte write on rising clk when imem_we = 1.
- Contents are not reset; the bench loads the program before releasing rst_n.

Test Plan:
- Reset, then set registers by write-back: rdx=5, rcx=3 via wb_dstE. Program "30 F2 0A 00..00" at pc=0 -> icode=3, rB=2, valC=10, valP=10, valE=10, dstE=2, instr_valid=1.
- "60 21" (addq rdx,rcx) with rdx=5, rcx=3 -> valE=8, dstE=1. After clk, cc=000. Then "61 21" with rdx=rcx=7 -> valE=0; after clk cc=100.
- addq 0x7FFFFFFFFFFFFFFF + 1 -> valE=0x8000000000000000; after clk cc=011. Then "73" je with cc=011 -> cnd=0, valP=pc+9.
- "A0 3F" pushq rbx, rsp=0x100 -> srcA=3, srcB=4, valE=0xF8, dstE=4. "B0 3F" popq -> valE=0x108, dstM=3.
- pc=IMEM_BYTES-1 holding 0x30 -> imem_error=1. pc=IMEM_BYTES -> imem_error=1, icode=1. Byte 0xC0 -> instr_valid=0. Byte 0x00 -> hlt=1, valP=pc+1.
- Assert rst_n mid-run -> cc=100 and all registers=0 immediately, without waiting for a clock edge. Same-edge wb_dstE=wb_dstM=5 -> rbp takes wb_valM.

Source files
------------

// File: rtl/y86_fde_core.sv
// Y86-64 SEQ front end: fetch, decode and execute with the instruction
// byte memory, the 16x64 register file and the condition-code register.
module y86_fde_core #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    input  logic [3:0]  wb_dstE,
    input  logic [63:0] wb_valE,
    input  logic [3:0]  wb_dstM,
    input  logic [63:0] wb_valM,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    output logic        imem_error,
    output logic        hlt,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc
);

    localparam int          AW      = $clog2(IMEM_BYTES);
    localparam logic [63:0] MEM_TOP = 64'(IMEM_BYTES);
    localparam logic [3:0]  RNONE   = 4'hF;
    localparam logic [3:0]  RSP     = 4'h4;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    logic [7:0]  imem_q [IMEM_BYTES];
    logic [63:0] rf_q   [16];
    logic [2:0]  cc_q;
    logic [2:0]  cc_d;
    logic        cc_ld;

    logic        pc_oob;
    logic        need_reg;
    logic        need_valc;
    logic [7:0]  b0;
    logic [63:0] ilen;
    logic [63:0] cbase;
    logic [63:0] last;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] res;
    logic        of;

    // Out-of-range byte reads return zero.
    function automatic logic [7:0] rd_byte(input logic [63:0] a);
        if (a < MEM_TOP) begin
            return imem_q[a[AW-1:0]];
        end
        return 8'h00;
    endfunction

    // Program load port; contents survive reset.
    always_ff @(posedge clk) begin
        if (imem_we && (imem_waddr < MEM_TOP)) begin
            imem_q[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    // Fetch: split the instruction bytes and compute its length.
    always_comb begin
        pc_oob = (pc >= MEM_TOP);
        b0     = rd_byte(pc);
        if (pc_oob) begin
            icode = I_NOP;
            ifun  = 4'h0;
        end else begin
            icode = b0[7:4];
            ifun  = b0[3:0];
        end
        need_reg  = 1'b0;
        need_valc = 1'b0;
        ilen      = 64'd1;
        case (icode)
            I_RRMOV, I_OPQ, I_PUSH, I_POP: begin
                need_reg = 1'b1;
                ilen     = 64'd2;
            end
            I_IRMOV, I_RMMOV, I_MRMOV: begin
                need_reg  = 1'b1;
                need_valc = 1'b1;
                ilen      = 64'd10;
            end
            I_JXX, I_CALL: begin
                need_valc = 1'b1;
                ilen      = 64'd9;
            end
            default: ilen = 64'd1;
        endcase
        if (need_reg) begin
            {rA, rB} = rd_byte(pc + 64'd1);
        end else begin
            rA = RNONE;
            rB = RNONE;
        end
        cbase = need_reg ? pc + 64'd2 : pc + 64'd1;
        valC  = '0;
        if (need_valc) begin
            for (int k = 0; k < 8; k++) begin
                valC[8*k +: 8] = rd_byte(cbase + 64'(k));
            end
        end
        valP       = pc + ilen;
        last       = valP - 64'd1;
        imem_error = pc_oob || (last >= MEM_TOP);
        hlt        = (icode == I_HALT);
        case (icode)
            I_RRMOV, I_JXX: instr_valid = (ifun <= 4'd6);
            I_OPQ:          instr_valid = (ifun <= 4'd3);
            I_HALT, I_NOP, I_IRMOV, I_RMMOV, I_MRMOV,
            I_CALL, I_RET, I_PUSH, I_POP:
                            instr_valid = (ifun == 4'h0);
            default:        instr_valid = 1'b0;
        endcase
    end

    // Branch / conditional-move outcome from the stored flags.
    always_comb begin
        cnd = 1'b0;
        if ((icode == I_RRMOV) || (icode == I_JXX)) begin
            case (ifun)
                4'd0:    cnd = 1'b1;
                4'd1:    cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
                4'd2:    cnd = cc_q[1] ^ cc_q[0];
                4'd3:    cnd = cc_q[2];
                4'd4:    cnd = ~cc_q[2];
                4'd5:    cnd = ~(cc_q[1] ^ cc_q[0]);
                4'd6:    cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
                default: cnd = 1'b0;
            endcase
        end
    end

    // Decode: register ids and register-file reads.
    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            I_RRMOV: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            I_IRMOV: dstE = rB;
            I_RMMOV: begin
                srcA = rA;
                srcB = rB;
            end
            I_MRMOV: begin
                srcB = rB;
                dstM = rA;
            end
            I_OPQ: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            I_CALL: begin
                srcB = RSP;
                dstE = RSP;
            end
            I_RET: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            I_PUSH: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            I_POP: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
        valA = (srcA == RNONE) ? 64'd0 : rf_q[srcA];
        valB = (srcB == RNONE) ? 64'd0 : rf_q[srcB];
    end

    // Execute: operand selection, ALU and new flag values.
    always_comb begin
        alu_a = 64'd0;
        alu_b = valB;
        case (icode)
            I_RRMOV, I_OPQ:           alu_a = valA;
            I_IRMOV, I_RMMOV, I_MRMOV: alu_a = valC;
            I_CALL, I_PUSH:           alu_a = -64'd8;
            I_RET, I_POP:             alu_a = 64'd8;
            default:                  alu_a = 64'd0;
        endcase
        if ((icode == I_RRMOV) || (icode == I_IRMOV)) begin
            alu_b = 64'd0;
        end
        res = alu_b + alu_a;
        of  = (alu_a[63] == alu_b[63]) && (res[63] != alu_a[63]);
        if (icode == I_OPQ) begin
            case (ifun)
                4'd1: begin
                    res = alu_b - alu_a;
                    of  = (alu_a[63] != alu_b[63]) && (res[63] != alu_b[63]);
                end
                4'd2: begin
                    res = alu_b & alu_a;
                    of  = 1'b0;
                end
                4'd3: begin
                    res = alu_b ^ alu_a;
                    of  = 1'b0;
                end
                default: ;
            endcase
        end
        valE  = res;
        cc_d  = {(res == 64'd0), res[63], of};
        cc_ld = (icode == I_OPQ) && instr_valid && !imem_error;
        cc    = cc_q;
    end

    // Condition-code register, loaded only by legal OPq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else if (cc_ld) begin
            cc_q <= cc_d;
        end
    end

    // Register file write-back; port M wins on a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 64'd0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (wb_dstM == 4'(i)) begin
                    rf_q[i] <= wb_valM;
                end else if (wb_dstE == 4'(i)) begin
                    rf_q[i] <= wb_valE;
                end
            end
        end
    end

endmodule

// File: tb/tb_y86_fde_core.sv
// Directed bench for y86_fde_core: stimulus queues expected values,
// a negedge monitor pops and compares them.
module tb_y86_fde_core;

    localparam int IMEM = 1024;

    localparam int S_ICODE = 0;
    localparam int S_IFUN  = 1;
    localparam int S_RA    = 2;
    localparam int S_RB    = 3;
    localparam int S_VALC  = 4;
    localparam int S_VALP  = 5;
    localparam int S_VALID = 6;
    localparam int S_IERR  = 7;
    localparam int S_HLT   = 8;
    localparam int S_SRCA  = 9;
    localparam int S_SRCB  = 10;
    localparam int S_DSTE  = 11;
    localparam int S_DSTM  = 12;
    localparam int S_VALA  = 13;
    localparam int S_VALB  = 14;
    localparam int S_VALE  = 15;
    localparam int S_CND   = 16;
    localparam int S_CC    = 17;

    typedef struct {
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [63:0] pc;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [3:0]  wb_dstE;
    logic [63:0] wb_valE;
    logic [3:0]  wb_dstM;
    logic [63:0] wb_valM;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        instr_valid;
    logic        imem_error;
    logic        hlt;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;

    logic [7:0] prog [35] = '{
        8'h30, 8'hF2, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h60, 8'h21,
        8'h61, 8'h21,
        8'h73, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h00,
        8'hA0, 8'h3F,
        8'hB0, 8'h3F,
        8'h00,
        8'hC0,
        8'h10,
        8'h22, 8'h12,
        8'h60, 8'h55
    };

    y86_fde_core #(.IMEM_BYTES(IMEM)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .wb_dstE(wb_dstE), .wb_valE(wb_valE),
        .wb_dstM(wb_dstM), .wb_valM(wb_valM),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .instr_valid(instr_valid),
        .imem_error(imem_error), .hlt(hlt),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valA(valA), .valB(valB), .valE(valE), .cnd(cnd), .cc(cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] get(input int sel);
        case (sel)
            S_ICODE: return 64'(icode);
            S_IFUN:  return 64'(ifun);
            S_RA:    return 64'(rA);
            S_RB:    return 64'(rB);
            S_VALC:  return valC;
            S_VALP:  return valP;
            S_VALID: return 64'(instr_valid);
            S_IERR:  return 64'(imem_error);
            S_HLT:   return 64'(hlt);
            S_SRCA:  return 64'(srcA);
            S_SRCB:  return 64'(srcB);
            S_DSTE:  return 64'(dstE);
            S_DSTM:  return 64'(dstM);
            S_VALA:  return valA;
            S_VALB:  return valB;
            S_VALE:  return valE;
            S_CND:   return 64'(cnd);
            S_CC:    return 64'(cc);
            default: return 64'hDEAD;
        endcase
    endfunction

    task automatic expect_v(input int sel, input logic [63:0] v,
                            input string nm);
        exp_t e;
        e.sel  = sel;
        e.exp  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        imem_we    = 1'b1;
        imem_waddr = 64'(a);
        imem_wdata = d;
        step();
        imem_we    = 1'b0;
    endtask

    task automatic wbe(input logic [3:0] r, input logic [63:0] v);
        wb_dstE = r;
        wb_valE = v;
        step();
        wb_dstE = 4'hF;
    endtask

    // Monitor: every negedge, compare all pending expectations.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                exp_t e;
                logic [63:0] got;
                e   = q.pop_front();
                got = get(e.sel);
                n_cmp++;
                if (got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %h want %h", e.name, got, e.exp);
                end
            end
        end
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        pc         = 64'd30;
        imem_we    = 1'b0;
        imem_waddr = 64'd0;
        imem_wdata = 8'h00;
        wb_dstE    = 4'hF;
        wb_valE    = 64'd0;
        wb_dstM    = 4'hF;
        wb_valM    = 64'd0;

        for (int a = 0; a < IMEM; a++) begin
            if (a < 35) wr(a, prog[a]);
            else if (a == IMEM - 1) wr(a, 8'h30);
            else wr(a, 8'h00);
        end

        pc = 64'd10;
        expect_v(S_CC, 64'd4, "rst_cc");
        expect_v(S_VALA, 64'd0, "rst_valA");
        expect_v(S_VALB, 64'd0, "rst_valB");
        expect_v(S_VALE, 64'd0, "rst_valE");
        step();
        rst_n = 1'b1;
        pc    = 64'd30;
        wbe(4'h2, 64'd5);
        wbe(4'h1, 64'd3);

        pc = 64'd0;
        expect_v(S_ICODE, 64'd3, "irm_icode");
        expect_v(S_RA, 64'hF, "irm_rA");
        expect_v(S_RB, 64'd2, "irm_rB");
        expect_v(S_VALC, 64'd10, "irm_valC");
        expect_v(S_VALP, 64'd10, "irm_valP");
        expect_v(S_VALE, 64'd10, "irm_valE");
        expect_v(S_DSTE, 64'd2, "irm_dstE");
        expect_v(S_VALID, 64'd1, "irm_valid");
        expect_v(S_IERR, 64'd0, "irm_ierr");
        step();

        pc = 64'd10;
        expect_v(S_SRCA, 64'd2, "add_srcA");
        expect_v(S_SRCB, 64'd1, "add_srcB");
        expect_v(S_VALA, 64'd5, "add_valA");
        expect_v(S_VALB, 64'd3, "add_valB");
        expect_v(S_VALE, 64'd8, "add_valE");
        expect_v(S_DSTE, 64'd1, "add_dstE");
        step();
        pc = 64'd30;
        expect_v(S_CC, 64'd0, "add_cc");
        step();

        wbe(4'h2, 64'd7);
        wbe(4'h1, 64'd7);
        pc = 64'd12;
        expect_v(S_VALE, 64'd0, "sub_valE");
        step();
        pc = 64'd30;
        expect_v(S_CC, 64'd4, "sub_cc");
        step();

        wbe(4'h2, 64'd1);
        wbe(4'h1, 64'h7FFF_FFFF_FFFF_FFFF);
        pc = 64'd10;
        expect_v(S_VALE, 64'h8000_0000_0000_0000, "ovf_valE");
        step();
        pc = 64'd30;
        expect_v(S_CC, 64'd3, "ovf_cc");
        step();

        pc = 64'd14;
        expect_v(S_ICODE, 64'd7, "je_icode");
        expect_v(S_IFUN, 64'd3, "je_ifun");
        expect_v(S_CND, 64'd0, "je_cnd");
        expect_v(S_VALC, 64'h40, "je_valC");
        expect_v(S_VALP, 64'd23, "je_valP");
        step();

        pc = 64'd31;
        expect_v(S_CND, 64'd0, "cmovl_cnd");
        expect_v(S_DSTE, 64'hF, "cmovl_dstE");
        expect_v(S_SRCA, 64'd1, "cmovl_srcA");
        step();

        wbe(4'h4, 64'h100);
        wbe(4'h3, 64'h55);
        pc = 64'd24;
        expect_v(S_SRCA, 64'd3, "push_srcA");
        expect_v(S_SRCB, 64'd4, "push_srcB");
        expect_v(S_VALA, 64'h55, "push_valA");
        expect_v(S_VALE, 64'hF8, "push_valE");
        expect_v(S_DSTE, 64'd4, "push_dstE");
        step();

        pc = 64'd26;
        expect_v(S_SRCA, 64'd4, "pop_srcA");
        expect_v(S_VALE, 64'h108, "pop_valE");
        expect_v(S_DSTM, 64'd3, "pop_dstM");
        expect_v(S_DSTE, 64'd4, "pop_dstE");
        step();

        pc = 64'd28;
        expect_v(S_HLT, 64'd1, "halt_hlt");
        expect_v(S_VALP, 64'd29, "halt_valP");
        expect_v(S_VALID, 64'd1, "halt_valid");
        step();

        pc = 64'd29;
        expect_v(S_VALID, 64'd0, "bad_valid");
        expect_v(S_HLT, 64'd0, "bad_hlt");
        step();

        pc = 64'(IMEM - 1);
        expect_v(S_IERR, 64'd1, "edge_ierr");
        expect_v(S_ICODE, 64'd3, "edge_icode");
        step();

        pc = 64'(IMEM);
        expect_v(S_IERR, 64'd1, "oob_ierr");
        expect_v(S_ICODE, 64'd1, "oob_icode");
        expect_v(S_IFUN, 64'd0, "oob_ifun");
        expect_v(S_VALP, 64'(IMEM + 1), "oob_valP");
        step();

        pc    = 64'd10;
        rst_n = 1'b0;
        expect_v(S_CC, 64'd4, "arst_cc");
        expect_v(S_VALA, 64'd0, "arst_valA");
        expect_v(S_VALB, 64'd0, "arst_valB");
        step();
        rst_n = 1'b1;
        pc    = 64'd30;

        wb_dstE = 4'h5;
        wb_valE = 64'hAAAA;
        wb_dstM = 4'h5;
        wb_valM = 64'hBBBB;
        step();
        wb_dstE = 4'hF;
        wb_dstM = 4'hF;
        pc = 64'd33;
        expect_v(S_VALA, 64'hBBBB, "coll_valA");
        expect_v(S_VALB, 64'hBBBB, "coll_valB");
        step();
        pc = 64'd30;
        step();
        step();

        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
